// File: rtl/spi_rx_trig_gen.sv
// Passive SPI frame snooper: captures one frame per SS_n low period, checks length,
// compares against match/mask and fires SPItrig after trig_thr matching frames.
module spi_rx_trig_gen #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              edg,
  input  logic              lsb_first,
  input  logic [2:0]        len_bytes,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] match,
  input  logic [7:0]        trig_thr,
  input  logic              clr_cnt,
  output logic              SPItrig,
  output logic              rx_vld,
  output logic [DATA_W-1:0] rx_data,
  output logic              frame_err,
  output logic [7:0]        match_cnt,
  output logic [1:0]        fsm_state_o
);

  localparam logic [2:0] NB = 3'(DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    EVAL = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] ss_q, sclk_q, mosi_q;
  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      sr_q, sr_d;
  logic [5:0]             bcnt_q, bcnt_d;
  logic [2:0]             len_q, len_d;
  logic                   lsb_q, lsb_d, edg_q, edg_d, ovr_q, ovr_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   trig_q, trig_d, vld_q, vld_d, err_q, err_d;

  logic              ss_s, ss_rise, sclk_rise, sclk_fall, sel_edge, bit_s, hit;
  logic [2:0]        len_in;
  logic [5:0]        lim;
  logic [DATA_W-1:0] len_mask;
  logic [7:0]        n_cnt, thr_eff;

  // Newest synchronised sample is index SYNC_STAGES-2, oldest is SYNC_STAGES-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q   <= '1;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      ss_q   <= {ss_q[SYNC_STAGES-2:0], SS_n};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
    end
  end

  assign ss_s      = ss_q[SYNC_STAGES-1];
  assign ss_rise   = ss_q[SYNC_STAGES-2] & ~ss_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q[SYNC_STAGES-2] & ~sclk_q[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-2] & sclk_q[SYNC_STAGES-1];
  assign bit_s     = mosi_q[SYNC_STAGES-1];
  assign sel_edge  = edg_q ? sclk_rise : sclk_fall;

  assign len_in  = ((len_bytes == 3'd0) || (len_bytes > NB)) ? NB : len_bytes;
  assign lim     = {len_q, 3'b000};
  assign n_cnt   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
  assign thr_eff = (trig_thr == 8'd0) ? 8'd1 : trig_thr;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      len_mask[i] = (6'(i) < lim);
    end
  end

  // Bits beyond the frame length never affect the compare.
  assign hit = &(mask | ~(sr_q ^ match) | ~len_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bcnt_q    <= '0;
      len_q     <= '0;
      lsb_q     <= 1'b0;
      edg_q     <= 1'b0;
      ovr_q     <= 1'b0;
      rx_data_q <= '0;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bcnt_q    <= bcnt_d;
      len_q     <= len_d;
      lsb_q     <= lsb_d;
      edg_q     <= edg_d;
      ovr_q     <= ovr_d;
      rx_data_q <= rx_data_d;
      cnt_q     <= cnt_d;
      trig_q    <= trig_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bcnt_d    = bcnt_q;
    len_d     = len_q;
    lsb_d     = lsb_q;
    edg_d     = edg_q;
    ovr_d     = ovr_q;
    rx_data_d = rx_data_q;
    cnt_d     = cnt_q;
    trig_d    = 1'b0;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ss_s) begin
          state_d = RX;
          len_d   = len_in;
          lsb_d   = lsb_first;
          edg_d   = edg;
          sr_d    = '0;
          bcnt_d  = '0;
          ovr_d   = 1'b0;
        end
      end
      RX: begin
        // A shift edge coinciding with SS_n rising is still taken.
        if (sel_edge) begin
          if (bcnt_q < lim) begin
            if (lsb_q) begin
              sr_d = (sr_q & ~(DATA_W'(1) << bcnt_q)) | (DATA_W'(bit_s) << bcnt_q);
            end else begin
              sr_d = {sr_q[DATA_W-2:0], bit_s};
            end
            bcnt_d = bcnt_q + 6'd1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        if (ss_rise) state_d = EVAL;
      end
      EVAL: begin
        state_d = IDLE;
        if ((bcnt_q == lim) && !ovr_q) begin
          vld_d     = 1'b1;
          rx_data_d = sr_q & len_mask;
          if (hit) begin
            if (n_cnt >= thr_eff) begin
              trig_d = 1'b1;
              cnt_d  = 8'd0;
            end else begin
              cnt_d  = n_cnt;
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Counter clear wins over any match, including one evaluated this cycle.
    if (clr_cnt) begin
      cnt_d  = 8'd0;
      trig_d = 1'b0;
    end
  end

  assign SPItrig     = trig_q;
  assign rx_vld      = vld_q;
  assign rx_data     = rx_data_q;
  assign frame_err   = err_q;
  assign match_cnt   = cnt_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_spi_rx_trig_gen.sv
// Bench for spi_rx_trig_gen: directed vector table, random frames against an
// arithmetic frame model, and a reset-mid-frame sequence.
module tb_spi_rx_trig_gen;

  localparam int DATA_W = 16;
  localparam int SYNC   = 3;
  localparam int H      = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic              edg = 1'b1, lsb_first = 1'b0, clr_cnt = 1'b0;
  logic [2:0]        len_bytes = 3'd2;
  logic [DATA_W-1:0] mask = '0, match = '0;
  logic [7:0]        trig_thr = 8'd1;
  logic              SPItrig, rx_vld, frame_err;
  logic [DATA_W-1:0] rx_data;
  logic [7:0]        match_cnt;
  logic [1:0]        fsm_state;

  spi_rx_trig_gen #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .edg(edg), .lsb_first(lsb_first), .len_bytes(len_bytes),
    .mask(mask), .match(match), .trig_thr(trig_thr), .clr_cnt(clr_cnt),
    .SPItrig(SPItrig), .rx_vld(rx_vld), .rx_data(rx_data),
    .frame_err(frame_err), .match_cnt(match_cnt), .fsm_state_o(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic [2:0]  len;
    logic        lsb;
    logic        edg;
    logic [15:0] mask;
    logic [15:0] match;
    logic [7:0]  thr;
    logic        clr;
    logic        e_vld;
    logic        e_trig;
    logic        e_err;
    logic [15:0] e_rx;
    logic [7:0]  e_cnt;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  int o_vld, o_trig, o_err, o_first;
  int m_cnt = 0;
  logic [15:0] m_rx = '0;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drives one frame, then watches a bounded window after SS_n rises.
  task automatic run_frame(input vec_t v);
    len_bytes = v.len; lsb_first = v.lsb; edg = v.edg;
    mask = v.mask; match = v.match; trig_thr = v.thr;
    wait_clks(2);
    SS_n = 1'b0;
    wait_clks(H);
    for (int k = 0; k < v.nbits; k++) begin
      MOSI = v.lsb ? v.data[k] : v.data[v.nbits-1-k];
      wait_clks(H);
      SCLK = 1'b1;
      wait_clks(H);
      SCLK = 1'b0;
      wait_clks(H);
    end
    SS_n = 1'b1;
    clr_cnt = v.clr;
    o_vld = 0; o_trig = 0; o_err = 0; o_first = 0;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (rx_vld) o_vld++;
      if (SPItrig) o_trig++;
      if (frame_err) o_err++;
      if (o_first == 0 && (rx_vld || SPItrig || frame_err)) o_first = j;
    end
    clr_cnt = 1'b0;
    wait_clks(1);
  endtask

  // Frame-level reference: length rule, masked compare, thresholded counter.
  task automatic model_frame(input vec_t v, output logic e_vld, output logic e_trig,
                             output logic e_err, output logic [15:0] e_rx,
                             output logic [7:0] e_cnt);
    int L, bits, n, t;
    logic [31:0] lm, val;
    logic good, hit;
    L    = (v.len == 0 || v.len > DATA_W / 8) ? DATA_W / 8 : int'(v.len);
    bits = 8 * L;
    lm   = (32'd1 << bits) - 32'd1;
    good = (v.nbits == bits);
    val  = v.data & lm;
    hit  = (((val ^ {16'd0, v.match}) & ~{16'd0, v.mask} & lm) == 32'd0);
    e_vld = good; e_err = !good; e_trig = 1'b0;
    if (good) m_rx = val[15:0];
    if (v.clr) m_cnt = 0;
    else if (good && hit) begin
      n = (m_cnt == 255) ? 255 : m_cnt + 1;
      t = (v.thr == 0) ? 1 : int'(v.thr);
      if (n >= t) begin
        e_trig = 1'b1;
        m_cnt = 0;
      end else m_cnt = n;
    end
    e_rx = m_rx;
    e_cnt = 8'(m_cnt);
  endtask

  task automatic check_frame(input string tag, input logic e_vld, input logic e_trig,
                             input logic e_err, input logic [15:0] e_rx, input logic [7:0] e_cnt);
    chk({tag, " rx_vld"}, o_vld, {31'd0, e_vld});
    chk({tag, " SPItrig"}, o_trig, {31'd0, e_trig});
    chk({tag, " frame_err"}, o_err, {31'd0, e_err});
    chk({tag, " rx_data"}, {16'd0, rx_data}, {16'd0, e_rx});
    chk({tag, " match_cnt"}, {24'd0, match_cnt}, {24'd0, e_cnt});
    if (e_vld || e_err) chk({tag, " pulse_time"}, o_first, SYNC + 1);
  endtask

  function automatic vec_t mk(logic [31:0] d, int nb, logic [2:0] len, logic lsb, logic e,
                              logic [15:0] msk, logic [15:0] mt, logic [7:0] thr, logic clr,
                              logic ev, logic et, logic ee, logic [15:0] erx, logic [7:0] ec);
    vec_t v;
    v.data = d; v.nbits = nb; v.len = len; v.lsb = lsb; v.edg = e;
    v.mask = msk; v.match = mt; v.thr = thr; v.clr = clr;
    v.e_vld = ev; v.e_trig = et; v.e_err = ee; v.e_rx = erx; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    vec_t v;
    logic ev, et, ee;
    logic [15:0] erx;
    logic [7:0] ec;
    logic [31:0] lm;
    int L;

    tbl[0]  = mk(32'hA5C3, 16, 2, 0, 1, 16'h0000, 16'hA5C3, 1, 0, 1, 1, 0, 16'hA5C3, 0);
    tbl[1]  = mk(32'h003C,  8, 1, 0, 1, 16'h0000, 16'hFF3C, 1, 0, 1, 1, 0, 16'h003C, 0);
    tbl[2]  = mk(32'h123F, 16, 2, 0, 1, 16'h000F, 16'h1230, 1, 0, 1, 1, 0, 16'h123F, 0);
    tbl[3]  = mk(32'h133F, 16, 2, 0, 1, 16'h000F, 16'h1230, 1, 0, 1, 0, 0, 16'h133F, 0);
    tbl[4]  = mk(32'hBEEF, 16, 2, 0, 1, 16'h0000, 16'hBEEF, 3, 0, 1, 0, 0, 16'hBEEF, 1);
    tbl[5]  = mk(32'hBEEF, 16, 2, 0, 1, 16'h0000, 16'hBEEF, 3, 0, 1, 0, 0, 16'hBEEF, 2);
    tbl[6]  = mk(32'hBEEF, 16, 2, 0, 1, 16'h0000, 16'hBEEF, 3, 0, 1, 1, 0, 16'hBEEF, 0);
    tbl[7]  = mk(32'hBEEF, 16, 2, 0, 1, 16'h0000, 16'hBEEF, 3, 0, 1, 0, 0, 16'hBEEF, 1);
    tbl[8]  = mk(32'hBEEF, 16, 2, 0, 1, 16'h0000, 16'hBEEF, 3, 0, 1, 0, 0, 16'hBEEF, 2);
    tbl[9]  = mk(32'hBEEF, 16, 2, 0, 1, 16'h0000, 16'hBEEF, 3, 1, 1, 0, 0, 16'hBEEF, 0);
    tbl[10] = mk(32'h0ABC, 12, 2, 0, 1, 16'h0000, 16'hBEEF, 1, 0, 0, 0, 1, 16'hBEEF, 0);
    tbl[11] = mk(32'h1FFFF, 17, 2, 0, 1, 16'h0000, 16'hBEEF, 1, 0, 0, 0, 1, 16'hBEEF, 0);
    tbl[12] = mk(32'hA5C3, 16, 2, 1, 0, 16'hFFFF, 16'h0000, 1, 0, 1, 1, 0, 16'hA5C3, 0);
    tbl[13] = mk(32'h5A5A, 16, 0, 0, 1, 16'hFFFF, 16'h0000, 0, 0, 1, 1, 0, 16'h5A5A, 0);
    tbl[14] = mk(32'h0000,  0, 1, 0, 1, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, 16'h5A5A, 0);

    wait_clks(3);
    @(negedge clk);
    chk("reset rx_data", {16'd0, rx_data}, 32'd0);
    chk("reset match_cnt", {24'd0, match_cnt}, 32'd0);
    chk("reset pulses", {29'd0, SPItrig, rx_vld, frame_err}, 32'd0);
    chk("reset state", {30'd0, fsm_state}, 32'd0);
    wait_clks(1);
    rst = 1'b0;
    wait_clks(2);

    for (int i = 0; i < 15; i++) begin
      run_frame(tbl[i]);
      model_frame(tbl[i], ev, et, ee, erx, ec);
      check_frame($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_trig, tbl[i].e_err,
                  tbl[i].e_rx, tbl[i].e_cnt);
    end

    for (int i = 0; i < 40; i++) begin
      v.len  = 3'($urandom_range(0, 3));
      L      = (v.len == 0 || v.len > 2) ? 2 : int'(v.len);
      case ($urandom_range(0, 5))
        0:       v.nbits = 8 * L + 1;
        1:       v.nbits = $urandom_range(0, 8 * L - 1);
        default: v.nbits = 8 * L;
      endcase
      v.data = $urandom;
      if (v.nbits < 32) v.data = v.data & ((32'd1 << v.nbits) - 32'd1);
      v.lsb  = 1'($urandom_range(0, 1));
      v.edg  = 1'($urandom_range(0, 1));
      v.mask = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
      lm     = (32'd1 << (8 * L)) - 32'd1;
      v.match = 16'(v.data & lm);
      if ($urandom_range(0, 2) == 0) v.match = v.match ^ (16'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v.match[15:8] = 8'($urandom);
      v.thr  = 8'($urandom_range(0, 3));
      v.clr  = ($urandom_range(0, 9) == 0);
      run_frame(v);
      model_frame(v, ev, et, ee, erx, ec);
      check_frame($sformatf("rnd%0d", i), ev, et, ee, erx, ec);
    end

    // Reset in the middle of an LSB-first, falling-edge frame.
    len_bytes = 3'd2; lsb_first = 1'b1; edg = 1'b0; mask = 16'hFFFF; trig_thr = 8'd1;
    wait_clks(2);
    SS_n = 1'b0;
    wait_clks(H);
    for (int k = 0; k < 7; k++) begin
      MOSI = k[0];
      wait_clks(H);
      SCLK = 1'b1;
      wait_clks(H);
      SCLK = 1'b0;
      wait_clks(H);
    end
    rst = 1'b1;
    wait_clks(1);
    @(negedge clk);
    chk("midrst rx_data", {16'd0, rx_data}, 32'd0);
    chk("midrst match_cnt", {24'd0, match_cnt}, 32'd0);
    chk("midrst pulses", {29'd0, SPItrig, rx_vld, frame_err}, 32'd0);
    chk("midrst state", {30'd0, fsm_state}, 32'd0);
    SS_n = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    o_first = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (SPItrig || rx_vld || frame_err) o_first++;
    end
    chk("midrst no_pulse", o_first, 0);
    m_cnt = 0; m_rx = '0;
    v = mk(32'h1234, 16, 2, 1, 0, 16'hFFFF, 16'h0000, 1, 0, 1, 1, 0, 16'h1234, 0);
    run_frame(v);
    model_frame(v, ev, et, ee, erx, ec);
    check_frame("after_rst", v.e_vld, v.e_trig, v.e_err, v.e_rx, v.e_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_rx_trig_gen.md
Name: spi_rx_trig_gen

Overview:
- Parametrised SPI receive/trigger block and the successor to the fixed 16-bit SPI receive trigger.
- Passively snoops an SPI bus. Bus inputs are synchronised into the `clk` domain and one frame is captured per `SS_n` low period, from 1 to `DATA_W/8` bytes, MSB- or LSB-first, on a selectable `SCLK` edge.
- Each frame is checked for length and compared against `match`/`mask`.
- `SPItrig` fires only after a programmable number of matching frames. It feeds the capture trigger logic.

Parameters:
- `DATA_W`, 16, maximum frame width in bits. Legal values: 8, 16, 24, 32.
- `SYNC_STAGES`, 3, flops per synchroniser chain on `SS_n`/`SCLK`/`MOSI`. Must be ≥ 3.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `SS_n`  in  1  SPI slave select (async).
- `SCLK`  in  1  SPI clock (async).
- `MOSI`  in  1  SPI data (async).
- `edg`  in  1  1 = sample on `SCLK` rise, 0 = sample on `SCLK` fall.
- `lsb_first`  in  1  1 = first bit on the wire is bit 0.
- `len_bytes`  in  3  expected frame length in bytes. 0 or > `DATA_W/8` is treated as `DATA_W/8`.
- `mask`  in  `DATA_W`  1 = don't-care bit.
- `match`  in  `DATA_W`  compare value.
- `trig_thr`  in  8  matching frames per trigger. 0 is treated as 1.
- `clr_cnt`  in  1  synchronous clear of `match_cnt`.
- `SPItrig`  out  1  trigger pulse, one cycle.
- `rx_vld`  out  1  good-frame pulse, one cycle.
- `rx_data`  out  `DATA_W`  last good frame, right-aligned, zero-extended.
- `frame_err`  out  1  length-error pulse, one cycle.
- `match_cnt`  out  8  matches accumulated toward `trig_thr`.

Behaviour:
- Reset: `rst` high for ≥1 clk. Result: state IDLE, shift register, bit counter, `rx_data`, `match_cnt` all 0. `SPItrig`/`rx_vld`/`frame_err` = 0. Sync chains reset to `SS_n`=1, `SCLK`=0, `MOSI`=0.
- Reset mid-frame aborts the frame silently: no pulse.
- Sync: `s*[1..SYNC_STAGES]` per input.
- Edge detect compares stage `SYNC_STAGES-1` against stage `SYNC_STAGES`.
- The shifted bit is `MOSI` stage `SYNC_STAGES`.
- FSM states: IDLE, RX, EVAL.
- IDLE → RX when synced `SS_n`=0. On this transition, capture `len_bytes`, `lsb_first`, `edg`; clear the shift register and the bit counter (`bcnt`).
- RX, on a selected `SCLK` edge:
  - If `bcnt` < `8*len`: shift, then `bcnt`+1.
  - MSB-first: `sr` <= {`sr` << 1, bit}.
  - LSB-first: `sr[bcnt]` <= bit.
  - If `bcnt` == `8*len`: set the sticky overrun flag; no shift.
- RX → EVAL on synced `SS_n` rising edge. A shift edge in the same cycle is applied first.
- EVAL lasts exactly 1 cycle, then → IDLE.
  - Good frame = (`bcnt` == `8*len`) and no overrun.
  - Good: `rx_data` <= `sr` with bits ≥ `8*len` forced to 0; `rx_vld` pulses.
  - Bad: `frame_err` pulses; `rx_data` is unchanged; no compare.
- Compare (good frame only): match when, for every bit i < `8*len`, `mask[i]` | (`sr[i]` == `match[i]`). Bits ≥ `8*len` are ignored.
- On match, let n = `match_cnt`+1 (saturating at 255):
  - If n ≥ max(`trig_thr`,1): `SPItrig` pulses and `match_cnt` <= 0.
  - Else `match_cnt` <= n.
- `clr_cnt` has priority over everything else that updates `match_cnt`. If it is high during EVAL, the match is discarded: no `SPItrig`, `match_cnt` = 0. `rx_vld` still pulses.
- Pulse timing: `SPItrig`, `rx_vld`, `frame_err` are registered. They are high in the cycle after EVAL, i.e. exactly `SYNC_STAGES` clk edges after the edge that first samples `SS_n`=1 on the pin.
- `len_bytes`/`edg`/`lsb_first` changes mid-frame have no effect until the next frame.
- `mask`/`match`/`trig_thr` are sampled in EVAL.
- Minimum `SCLK` half-period: `SYNC_STAGES`+1 clk cycles.
- `SS_n` high with no `SCLK` edges gives `bcnt`=0, which is `frame_err`.
- `SS_n` low when reset is released: the frame is entered mid-stream. It is flagged `frame_err` unless the bit count happens to match; this is acceptable.

Test Plan:
- `DATA_W`=16, `len_bytes`=2, `edg`=1, MSB-first, send 0xA5C3, `match`=0xA5C3, `mask`=0, `trig_thr`=1 → `rx_vld`=1 and `SPItrig`=1 for one cycle, `SYNC_STAGES` edges after `SS_n` rise; `rx_data`=0xA5C3; `match_cnt`=0.
- `len_bytes`=1, send 0x3C, `match`=0xFF3C → `SPItrig`=1; `rx_data`=0x003C (upper byte ignored and zeroed).
- `mask`=0x000F, `match`=0x1230: send 0x123F → `SPItrig`=1; send 0x133F → `rx_vld`=1, `SPItrig`=0.
- `trig_thr`=3, three matching frames → `match_cnt` 1, 2, then `SPItrig` on the third and `match_cnt`=0. Repeat with `clr_cnt` high during the 3rd EVAL → no `SPItrig`, `match_cnt`=0.
- `len_bytes`=2, 12 `SCLK` edges → `frame_err`=1, `rx_vld`=0, `rx_data` unchanged. Same check with 17 edges → `frame_err`=1.
- `lsb_first`=1, `edg`=0, send 0xA5C3 LSB-first → `rx_data`=0xA5C3. Then assert `rst` after 7 bits of the next frame → all outputs 0, no pulse; the following clean frame 0x1234 → `rx_data`=0x1234.
